// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master bus arbiter with split-transaction support. A granted master
//   whose slave signals a split is parked (msplitx) while the other master
//   may use the bus. The parked master resumes when the slave finishes its
//   split latency (falling edge of ssplit). It is aborted if the split stays
//   pending for SPLIT_TIMEOUT cycles.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin priority for simultaneous requests in IDLE
//     undefined -> fixed priority, master 1 wins
//
// Parameters
//   SPLIT_TIMEOUT  1..255, cycles a split may stay pending before abort
// Ports
//   clk          clock, all logic on rising edge
//   rst          synchronous active-high reset
//   mreq1/2      master requests, held high for the whole transaction
//   ssplit       slave split indication (high during split latency)
//   mgrant1/2    bus grants
//   msplit1/2    master transaction split and pending
//   split_grant  one-cycle pulse: split slave may return read data
//   bsel         bus mux select, 0 = master 1, 1 = master 2
//   split_abort  one-cycle pulse: pending split timed out
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned SPLIT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mreq1,
  input  logic mreq2,
  input  logic ssplit,
  output logic mgrant1,
  output logic mgrant2,
  output logic msplit1,
  output logic msplit2,
  output logic split_grant,
  output logic bsel,
  output logic split_abort
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT1 = 3'd1,
    GRANT2 = 3'd2,
    SPLIT1 = 3'd3,
    SPLIT2 = 3'd4
  } state_t;

  // Counter value whose next increment would reach SPLIT_TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(SPLIT_TIMEOUT - 32'd1);

  state_t     state_r;
  logic [1:0] gnt_r;       // bit 0 = master 1, bit 1 = master 2
  logic [1:0] spl_r;
  logic       ready_r;     // split slave finished its latency phase
  logic       ssplit_q_r;  // registered copy of ssplit for edge detection
  logic [7:0] tcount_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic       rr_last_r;   // 1 = master 2 was the last IDLE grant
`endif

  logic [1:0] req_s;
  logic       cur_s;       // master owning the current GRANTx/SPLITx state
  logic       oth_s;       // the other master
  logic       both_pick2_s;
  logic       win_s;
  logic       ssplit_fall_s;

  assign req_s         = {mreq2, mreq1};
  assign cur_s         = (state_r == GRANT2) || (state_r == SPLIT2);
  assign oth_s         = ~cur_s;
  assign ssplit_fall_s = ssplit_q_r & ~ssplit;

`ifdef ARB_ROUND_ROBIN_EN
  assign both_pick2_s = ~rr_last_r;
`else
  assign both_pick2_s = 1'b0;
`endif

  // A lone requester always wins; simultaneous requests use the priority rule.
  assign win_s = (req_s == 2'b10) ? 1'b1 :
                 (req_s == 2'b11) ? both_pick2_s : 1'b0;

  assign mgrant1 = gnt_r[0];
  assign mgrant2 = gnt_r[1];
  assign msplit1 = spl_r[0];
  assign msplit2 = spl_r[1];

  // Arbitration FSM with registered grant, split, select and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= 2'b00;
      spl_r       <= 2'b00;
      bsel        <= 1'b0;
      split_grant <= 1'b0;
      split_abort <= 1'b0;
      ready_r     <= 1'b0;
      ssplit_q_r  <= 1'b0;
      tcount_r    <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_r   <= 1'b1;
`endif
    end else begin
      ssplit_q_r  <= ssplit;
      split_grant <= 1'b0;
      split_abort <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s != 2'b00) begin
            gnt_r[win_s] <= 1'b1;
            bsel         <= win_s;
            state_r      <= win_s ? GRANT2 : GRANT1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_r    <= win_s;
`endif
          end
        end
        GRANT1, GRANT2: begin
          if (!req_s[cur_s]) begin
            gnt_r[cur_s] <= 1'b0;
            state_r      <= IDLE;
          end else if (ssplit) begin
            gnt_r[cur_s] <= 1'b0;
            spl_r[cur_s] <= 1'b1;
            tcount_r     <= 8'd0;
            ready_r      <= 1'b0;
            state_r      <= cur_s ? SPLIT2 : SPLIT1;
          end
        end
        SPLIT1, SPLIT2: begin
          if (!spl_r[cur_s]) begin
            // Split already aborted: only finishing the other master's grant.
            if (!req_s[oth_s]) begin
              gnt_r[oth_s] <= 1'b0;
              state_r      <= IDLE;
            end
          end else if (ready_r) begin
            // Slave is ready; resume only once the other master is off the bus.
            if (gnt_r[oth_s]) begin
              if (!req_s[oth_s]) begin
                gnt_r[oth_s] <= 1'b0;
              end
            end else begin
              gnt_r[cur_s] <= 1'b1;
              spl_r[cur_s] <= 1'b0;
              bsel         <= cur_s;
              split_grant  <= 1'b1;
              ready_r      <= 1'b0;
              state_r      <= cur_s ? GRANT2 : GRANT1;
            end
          end else begin
            // Serve the other master while the split is outstanding.
            if (gnt_r[oth_s]) begin
              if (!req_s[oth_s]) begin
                gnt_r[oth_s] <= 1'b0;
              end
            end else if (req_s[oth_s]) begin
              gnt_r[oth_s] <= 1'b1;
              bsel         <= oth_s;
            end
            if (ssplit_fall_s) begin
              ready_r <= 1'b1;
            end else if (tcount_r == TMO_LAST) begin
              spl_r[cur_s] <= 1'b0;
              split_abort  <= 1'b1;
              // Other master still on the bus: stay here until it releases.
              if (!req_s[oth_s]) begin
                state_r <= IDLE;
              end
            end else begin
              tcount_r <= tcount_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          spl_r   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst, mreq1, mreq2, ssplit;
  logic mgrant1, mgrant2, msplit1, msplit2, split_grant, bsel, split_abort;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, who is parked on a split, and so on.
  int m_owner, m_parked, m_age, m_last, m_sel;
  bit m_rdy, m_sq, m_zombie, m_sg, m_sa;

  int cnt_g1, cnt_sg, cnt_sa;
  int exp_win [3];
  bit rr1, rr2, rss;

  always #5 clk = ~clk;

  bus_arbiter #(.SPLIT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mreq1(mreq1), .mreq2(mreq2), .ssplit(ssplit),
    .mgrant1(mgrant1), .mgrant2(mgrant2), .msplit1(msplit1), .msplit2(msplit2),
    .split_grant(split_grant), .bsel(bsel), .split_abort(split_abort)
  );

  function automatic bit rr_enabled();
`ifdef ARB_ROUND_ROBIN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input bit rs, input bit r1, input bit r2, input bit ss);
    bit req [3];
    int w;
    int oth;
    bit was_rdy;
    req[0] = 1'b0; req[1] = r1; req[2] = r2;
    was_rdy = m_rdy;
    m_sg = 1'b0;
    m_sa = 1'b0;
    if (rs) begin
      m_owner = 0; m_parked = 0; m_age = 0; m_last = 2; m_sel = 1;
      m_rdy = 1'b0; m_zombie = 1'b0;
    end else if (m_zombie) begin
      if (!req[m_owner]) begin m_owner = 0; m_zombie = 1'b0; end
    end else if (m_parked == 0) begin
      if (m_owner == 0) begin
        if (r1 && r2) w = (rr_enabled() && m_last == 1) ? 2 : 1;
        else if (r1) w = 1;
        else if (r2) w = 2;
        else w = 0;
        if (w != 0) begin m_owner = w; m_sel = w; m_last = w; end
      end else if (!req[m_owner]) begin
        m_owner = 0;
      end else if (ss) begin
        m_parked = m_owner; m_owner = 0; m_age = 0; m_rdy = 1'b0;
      end
    end else begin
      oth = 3 - m_parked;
      if (m_owner != 0) begin
        if (!req[oth]) m_owner = 0;
      end else if (was_rdy) begin
        m_owner = m_parked; m_sel = m_parked; m_parked = 0; m_rdy = 1'b0; m_sg = 1'b1;
      end else if (req[oth]) begin
        m_owner = oth; m_sel = oth;
      end
      if (!was_rdy) begin
        if (m_sq && !ss) m_rdy = 1'b1;
        else if (m_age == TMO - 1) begin
          m_sa = 1'b1; m_parked = 0;
          if (req[oth]) m_zombie = 1'b1;
        end else m_age++;
      end
    end
    m_sq = rs ? 1'b0 : ss;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rs, input bit r1, input bit r2, input bit ss);
    rst = rs; mreq1 = r1; mreq2 = r2; ssplit = ss;
    @(posedge clk);
    model_step(rs, r1, r2, ss);
    #1;
    chk("mgrant1", mgrant1, m_owner == 1);
    chk("mgrant2", mgrant2, m_owner == 2);
    chk("msplit1", msplit1, m_parked == 1);
    chk("msplit2", msplit2, m_parked == 2);
    chk("bsel", bsel, m_sel == 2);
    chk("split_grant", split_grant, m_sg);
    chk("split_abort", split_abort, m_sa);
    chk("grant_exclusive", mgrant1 & mgrant2, 1'b0);
    cnt_g1 += int'(mgrant1);
    cnt_sg += int'(split_grant);
    cnt_sa += int'(split_abort);
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_win = '{1, 2, 1};
`else
    exp_win = '{1, 1, 1};
`endif
    m_owner = 0; m_parked = 0; m_age = 0; m_last = 2; m_sel = 1;
    m_rdy = 1'b0; m_sq = 1'b0; m_zombie = 1'b0;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_mgrant1", mgrant1, 1'b0);
    chk("reset_bsel", bsel, 1'b0);

    // Single request for 10 cycles
    cnt_g1 = 0;
    repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("single_req_cycles", cnt_g1, 10);

    // Simultaneous requests, three rounds from a fresh reset
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("sim_winner_m1", mgrant1, exp_win[i] == 1);
      chk("sim_winner_m2", mgrant2, exp_win[i] == 2);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Split with interleaved master 2
    cnt_sg = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("split_entry_msplit1", msplit1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("interleave_mgrant2", mgrant2, 1'b1);
    chk("interleave_bsel", bsel, 1'b1);
    repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume_mgrant1", mgrant1, 1'b1);
    chk("resume_split_grant", split_grant, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("interleave_sg_pulses", cnt_sg, 1);

    // Split without contention
    cnt_sg = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("nocont_split_grant", split_grant, 1'b1);
    chk("nocont_mgrant1", mgrant1, 1'b1);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("nocont_sg_pulses", cnt_sg, 1);

    // Split timeout
    cnt_sg = 0; cnt_sa = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("timeout_abort", split_abort, 1'b1);
    chk("timeout_msplit1", msplit1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("timeout_abort_pulses", cnt_sa, 1);
    chk_cnt("timeout_no_split_grant", cnt_sg, 0);

    // Reset mid-split, then master 2 is granted normally
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_reset_msplit1", msplit1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_msplit1", msplit1, 1'b0);
    chk("rst_split_abort", split_abort, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_mgrant2", mgrant2, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model
    rr1 = 1'b0; rr2 = 1'b0; rss = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) rr1 = ~rr1;
      if ($urandom_range(5) == 0) rr2 = ~rr2;
      if ($urandom_range(3) == 0) rss = ~rss;
      tick($urandom_range(149) == 0, rr1, rr2, rss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter SPLIT_TIMEOUT, default 64, range 1..255: cycles a split may stay pending before it is aborted.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mreq1  input  1  master 1 bus request; held high for the whole transaction.
REQ-005 mreq2  input  1  master 2 bus request; held high for the whole transaction.
REQ-006 ssplit  input  1  slave split indication; high while the addressed slave is in its split latency phase.
REQ-007 mgrant1  output  1  bus granted to master 1.
REQ-008 mgrant2  output  1  bus granted to master 2.
REQ-009 msplit1  output  1  master 1 transaction is split and pending.
REQ-010 msplit2  output  1  master 2 transaction is split and pending.
REQ-011 split_grant  output  1  single-cycle pulse permitting the split slave to return read data.
REQ-012 bsel  output  1  bus mux select; 0 = master 1, 1 = master 2.
REQ-013 split_abort  output  1  single-cycle pulse when a pending split times out.

Function
REQ-014 States: IDLE, GRANT1, GRANT2, SPLIT1, SPLIT2. All outputs are registered.
REQ-015 Outputs per state: GRANTx drives mgrantx=1. SPLITx drives msplitx=1 and mgrantx=0.
REQ-016 IDLE samples requests; the grant is visible on the cycle after the request is sampled.
REQ-017 Simultaneous mreq1 and mreq2 in IDLE: the winner is selected per REQ-031/032.
REQ-018 GRANTx with mreqx=0 -> IDLE.
  - Next cycle: mgrantx=0 and bsel holds its value.
  - Minimum of one IDLE cycle between any two grants.
REQ-019 GRANTx with mreqx=1 and ssplit=1 -> SPLITx.
  - Next cycle: mgrantx=0 and msplitx=1.
  - The timeout counter is cleared to 0.
REQ-020 SPLITx, other master (y) handling:
  - Other master y may be granted while x is split: mgranty=1, bsel=y.
  - Grant y when mreqy=1 and no y grant is active; y is granted on the next cycle.
  - The y grant ends when mreqy drops.
REQ-021 SPLITx: ssplit is edge-tracked through a registered copy.
  - A 1->0 transition sets an internal ready flag.
  - ssplit transitions during a y grant are not treated as a new split; only one split is outstanding.
REQ-022 SPLITx, ready flag set and no y grant active -> GRANTx. Next cycle:
  - mgrantx=1, msplitx=0, bsel=x
  - split_grant=1 for exactly one cycle
  - ready flag cleared
REQ-023 SPLITx, ready flag set while a y grant is active: resumption waits until mreqy drops; y is not re-granted while the ready flag is set.
REQ-024 SPLITx timeout counter:
  - Increments every cycle while the ready flag is 0.
  - On reaching SPLIT_TIMEOUT: msplitx=0, split_abort pulses one cycle, state -> IDLE (or stays serving y until mreqy drops, then IDLE).
  - split_grant is not issued on an abort.
REQ-025 A master whose msplitx=1 and whose mreqx stays high is not re-granted through IDLE arbitration; it resumes only via REQ-022.
REQ-026 mgrant1 and mgrant2 are never high in the same cycle.
REQ-027 msplit1 and msplit2 are never high in the same cycle.

Reset
REQ-028 rst=1 sampled at a clock edge -> state IDLE on the next cycle, with:
  - mgrant1, mgrant2, msplit1, msplit2, split_grant, split_abort, bsel = 0
  - ready flag, ssplit copy and timeout counter = 0
  - round-robin pointer = master 1 priority
REQ-029 Reset asserted mid-transaction or mid-split discards the pending split without a split_grant or split_abort pulse.
REQ-030 First grant after reset release: earliest on the second cycle following the first cycle with rst=0 and mreqx=1.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: round-robin priority.
  - On simultaneous requests in IDLE, the master not most recently granted wins.
  - The pointer updates on every grant from IDLE; resumption grants do not update it.
REQ-032 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority; master 1 always wins simultaneous requests in IDLE.

Verification
REQ-033 Single request: mreq1=1 for 10 cycles -> mgrant1=1 from cycle 2 to cycle 11, bsel=0, mgrant2=0 throughout.
REQ-034 Simultaneous requests: mreq1=mreq2=1 three times, each master dropping its request after its transaction.
  - Fixed priority: master 1 wins all three.
  - Round robin: winners are M1, M2, M1.
REQ-035 Split with interleave:
  - M1 granted; ssplit=1 for 4 cycles -> mgrant1=0, msplit1=1.
  - M2 requesting -> mgrant2=1, bsel=1; ssplit falls during the M2 grant.
  - M2 drops mreq2 -> mgrant1=1, split_grant pulses one cycle, msplit1=0.
REQ-036 Split without contention: ssplit high for 4 cycles and then low -> split_grant pulses one cycle after the ready flag is set, and mgrant1 returns in the same cycle.
REQ-037 Timeout: SPLIT_TIMEOUT=8, ssplit held high indefinitely -> split_abort pulses after 8 SPLIT cycles, msplit1=0, state IDLE, no split_grant.
REQ-038 Reset mid-split: assert rst while msplit1=1 -> next cycle all outputs 0, no pulses; a subsequent mreq2 is granted normally.
